stile_seq: RTL

STILE_SEQ -- requirements
Module: stile_seq

---
 rtl/stile_seq.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stile_seq.sv
// Sequenced MAC tile: streams len weight/activation pairs through a 4-stage
// pipeline and combines each product with a parallel, cascade or running sum.
module stile_seq #(
    parameter int WID_W       = 16,
    parameter int WID_ACT     = 16,
    parameter int WID_ACC     = 48,
    parameter int WID_WADDR   = 10,
    parameter int WID_ACTADDR = 6
) (
    input  logic                   clk_h,
    input  logic                   rst,
    input  logic                   w_wr_en,
    input  logic [WID_WADDR-1:0]   w_wr_addr,
    input  logic [WID_W-1:0]       w_wr_data,
    input  logic                   act_wr_en,
    input  logic [WID_ACTADDR-1:0] act_wr_addr,
    input  logic [WID_ACT-1:0]     act_wr_data,
    input  logic                   act_swap,
    input  logic                   start,
    input  logic [WID_ACTADDR:0]   len,
    input  logic [WID_WADDR-1:0]   w_base,
    input  logic [1:0]             op_sel,
    input  logic [WID_ACC-1:0]     p_sumin,
    input  logic [WID_ACC-1:0]     p_casin,
    output logic [WID_ACC-1:0]     p_out,
    output logic [WID_ACC-1:0]     p_casout,
    output logic                   p_valid,
    output logic                   p_last,
    output logic                   busy,
    output logic                   done
);

    localparam int WID_LEN  = WID_ACTADDR + 1;
    localparam int WID_PROD = WID_W + WID_ACT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [WID_LEN-1:0]   r_cnt;
    logic [1:0]           r_drain;
    logic [WID_LEN-1:0]   r_len;
    logic [WID_WADDR-1:0] r_base;
    logic [1:0]           r_op;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_bank;
    logic                 r_swap_pend;

    // Buffers: weights flat, activations as {bank, addr}
    logic [WID_W-1:0]     r_wmem [0:(2**WID_WADDR)-1];
    logic [WID_ACT-1:0]   r_amem [0:(2**WID_LEN)-1];

    logic                 r_s1_v, r_s1_first, r_s1_last;
    logic [WID_WADDR-1:0] r_s1_waddr;
    logic [WID_LEN-1:0]   r_s1_aaddr;
    logic                 r_s2_v, r_s2_first, r_s2_last;
    logic [WID_W-1:0]     r_w_q;
    logic [WID_ACT-1:0]   r_a_q;
    logic                 r_s3_v, r_s3_first, r_s3_last;
    logic [WID_ACC-1:0]   r_m;
    logic [WID_ACC-1:0]   r_sumin;
    logic [WID_ACC-1:0]   r_casin;
    logic [WID_ACC-1:0]   r_p;
    logic                 r_p_valid;
    logic                 r_p_last;

    logic                   w_issue;
    logic                   w_first;
    logic                   w_last;
    logic [WID_WADDR-1:0]   w_waddr;
    logic signed [WID_PROD-1:0] w_prod;
    logic [WID_ACC-1:0]     w_prod_ext;
    logic [WID_ACC-1:0]     w_addend;

    assign w_issue    = (r_state == RUN);
    assign w_first    = (r_cnt == {WID_LEN{1'b0}});
    assign w_last     = (r_cnt == (r_len - {{(WID_LEN-1){1'b0}}, 1'b1}));
    assign w_waddr    = r_base + WID_WADDR'(r_cnt);
    assign w_prod     = $signed(r_w_q) * $signed(r_a_q);
    assign w_prod_ext = {{(WID_ACC-WID_PROD){w_prod[WID_PROD-1]}}, w_prod};

    // Run sequencer; swaps requested while busy are deferred to the DONE cycle
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= {WID_LEN{1'b0}};
            r_drain     <= 2'd0;
            r_len       <= {WID_LEN{1'b0}};
            r_base      <= {WID_WADDR{1'b0}};
            r_op        <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bank      <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (act_swap) begin
                        r_bank <= ~r_bank;
                    end
                    if (start) begin
                        r_busy <= 1'b1;
                        if (len == {WID_LEN{1'b0}}) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_len   <= len;
                            r_base  <= w_base;
                            r_op    <= op_sel;
                            r_cnt   <= {WID_LEN{1'b0}};
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (act_swap) begin
                        r_swap_pend <= 1'b1;
                    end
                    if (w_last) begin
                        r_drain <= 2'd0;
                        r_state <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + {{(WID_LEN-1){1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    if (act_swap) begin
                        r_swap_pend <= 1'b1;
                    end
                    if (r_drain == 2'd3) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_bank      <= r_bank ^ (r_swap_pend | act_swap);
                    r_swap_pend <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Buffer writes and read-first output registers
    always_ff @(posedge clk_h) begin
        if (w_wr_en) begin
            r_wmem[w_wr_addr] <= w_wr_data;
        end
        if (act_wr_en) begin
            r_amem[{~r_bank, act_wr_addr}] <= act_wr_data;
        end
        r_w_q <= r_wmem[r_s1_waddr];
        r_a_q <= r_amem[r_s1_aaddr];
    end

    // Address, read and product stages
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_waddr <= {WID_WADDR{1'b0}};
            r_s1_aaddr <= {WID_LEN{1'b0}};
            r_s2_v     <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_v     <= 1'b0;
            r_s3_first <= 1'b0;
            r_s3_last  <= 1'b0;
            r_m        <= {WID_ACC{1'b0}};
            r_sumin    <= {WID_ACC{1'b0}};
            r_casin    <= {WID_ACC{1'b0}};
        end else begin
            r_s1_v     <= w_issue;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_waddr <= w_waddr;
            r_s1_aaddr <= {r_bank, r_cnt[WID_ACTADDR-1:0]};
            r_s2_v     <= r_s1_v;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s3_v     <= r_s2_v;
            r_s3_first <= r_s2_first;
            r_s3_last  <= r_s2_last;
            r_m        <= w_prod_ext;
            r_sumin    <= p_sumin;
            r_casin    <= p_casin;
        end
    end

    // Second operand of the P adder; self-accumulate restarts on element 0
    always_comb begin
        w_addend = {WID_ACC{1'b0}};
        case (r_op)
            2'b00: w_addend = {WID_ACC{1'b0}};
            2'b01: w_addend = r_sumin;
            2'b10: w_addend = r_casin;
            2'b11: begin
                if (r_s3_first) begin
                    w_addend = {WID_ACC{1'b0}};
                end else begin
                    w_addend = r_p;
                end
            end
            default: w_addend = {WID_ACC{1'b0}};
        endcase
    end

    // P register: updates only on a valid element, otherwise holds
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            r_p       <= {WID_ACC{1'b0}};
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= r_s3_v;
            r_p_last  <= r_s3_v & r_s3_last;
            if (r_s3_v) begin
                r_p <= r_m + w_addend;
            end
        end
    end

    assign p_out    = r_p;
    assign p_casout = r_p;
    assign p_valid  = r_p_valid;
    assign p_last   = r_p_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
